// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and FSM state types for the LED pattern engine.
package led_pattern_pkg;

    localparam logic [1:0] MODE_ROTATE = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } bounce_state_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } fill_state_t;

endpackage

// File: rtl/led_pattern_engine_tick_prescaler.sv
// Step-rate prescaler: down-counter with terminal-count strobe.
// The reload value is sampled only when the counter reloads, so a speed
// change lands on the next step boundary rather than mid-period.
module tick_prescaler #(
    parameter int DIV_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       reload_req,
    input  logic [2:0] speed,
    output logic       tick
);

    localparam logic [DIV_BITS-1:0] DIV_MAX = '1;

    logic [DIV_BITS-1:0] div;
    logic [DIV_BITS-1:0] reload_val;

    // Shifting past the counter width leaves zero, i.e. a tick every cycle.
    assign reload_val = DIV_MAX >> speed;

    assign tick = en && (div == '0);

    // Counter: reload on reset, forced reload or terminal count; hold when disabled.
    always_ff @(posedge clk) begin
        if (rst || reload_req) begin
            div <= reload_val;
        end else if (en) begin
            if (div == '0) begin
                div <= reload_val;
            end else begin
                div <= div - 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: rotate, bounce, fill/drain and binary count over a
// WIDTH-bit LED bank, stepped by a programmable prescaler.
// Optional build macro LED_PATTERN_PWM_EN gates the LED output with a
// 16-step PWM brightness control driven by duty.
//
// Bounce FSM
//   state | meaning
//   UP    | lit bit moving toward MSB
//   DOWN  | lit bit moving toward LSB, wrap on arrival at bit 0
// Fill FSM
//   state | meaning
//   FILL  | ones shifting in from the entry end
//   DRAIN | zeros shifting in, wrap once the bank is empty
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DIV_BITS = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [2:0]       speed,
    input  logic [3:0]       duty,
    output logic [WIDTH-1:0] leds,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pat, pat_nxt;
    logic [1:0]       mode_q;
    bounce_state_t    bst, bst_nxt;
    fill_state_t      fst, fst_nxt;
    logic             wrap_q, wrap_nxt;
    logic             mode_chg;

    function automatic logic [WIDTH-1:0] start_value(input logic [1:0] m);
        if (m == MODE_ROTATE || m == MODE_BOUNCE) begin
            return ONE;
        end
        return ALL_ZERO;
    endfunction

    assign mode_chg = (mode != mode_q);

    tick_prescaler #(
        .DIV_BITS(DIV_BITS)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .reload_req(mode_chg),
        .speed     (speed),
        .tick      (tick)
    );

    // State register for pattern, mode tracking, FSM states and wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat    <= start_value(mode);
            mode_q <= mode;
            bst    <= UP;
            fst    <= FILL;
            wrap_q <= 1'b0;
        end else begin
            pat    <= pat_nxt;
            mode_q <= mode;
            bst    <= bst_nxt;
            fst    <= fst_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    // Next pattern: a mode change restarts the pattern ahead of any step.
    always_comb begin
        pat_nxt  = pat;
        bst_nxt  = bst;
        fst_nxt  = fst;
        wrap_nxt = 1'b0;
        if (mode_chg) begin
            pat_nxt = start_value(mode);
            bst_nxt = UP;
            fst_nxt = FILL;
        end else if (tick) begin
            case (mode_q)
                MODE_ROTATE: begin
                    if (dir) begin
                        pat_nxt  = {pat[WIDTH-2:0], pat[WIDTH-1]};
                        wrap_nxt = pat[WIDTH-1];
                    end else begin
                        pat_nxt  = {pat[0], pat[WIDTH-1:1]};
                        wrap_nxt = pat[0];
                    end
                end
                MODE_BOUNCE: begin
                    if (bst == UP) begin
                        pat_nxt = pat << 1;
                        if (pat_nxt[WIDTH-1]) begin
                            bst_nxt = DOWN;
                        end
                    end else begin
                        pat_nxt = pat >> 1;
                        if (pat_nxt[0]) begin
                            bst_nxt  = UP;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
                MODE_FILL: begin
                    if (fst == FILL) begin
                        pat_nxt = dir ? {pat[WIDTH-2:0], 1'b1} : {1'b1, pat[WIDTH-1:1]};
                        if (pat_nxt == ALL_ONES) begin
                            fst_nxt = DRAIN;
                        end
                    end else begin
                        pat_nxt = dir ? {pat[WIDTH-2:0], 1'b0} : {1'b0, pat[WIDTH-1:1]};
                        if (pat_nxt == ALL_ZERO) begin
                            fst_nxt  = FILL;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    if (dir) begin
                        pat_nxt  = pat + ONE;
                        wrap_nxt = (pat == ALL_ONES);
                    end else begin
                        pat_nxt  = pat - ONE;
                        wrap_nxt = (pat == ALL_ZERO);
                    end
                end
            endcase
        end
    end

    assign wrap = wrap_q;

`ifdef LED_PATTERN_PWM_EN
    logic [3:0] pwm;

    // Free-running brightness counter, independent of the run enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 4'd0;
        end else begin
            pwm <= pwm + 4'd1;
        end
    end

    assign leds = pat & {WIDTH{pwm < duty}};
`else
    logic unused_duty;
    assign unused_duty = ^duty;
    assign leds = pat;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine at WIDTH=4, DIV_BITS=4.
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       dir = 1'b1;
    logic [2:0] speed = 3'd0;
    logic [3:0] duty = 4'd15;
    logic [3:0] leds;
    logic       tick;
    logic       wrap;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] leds;
        logic       wrap;
        int         gap;
    } exp_t;

    exp_t sb[$];

    led_pattern_engine #(
        .WIDTH   (4),
        .DIV_BITS(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .dir  (dir),
        .speed(speed),
        .duty (duty),
        .leds (leds),
        .tick (tick),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

`ifdef LED_PATTERN_PWM_EN
    logic [3:0] tb_pwm = 4'd0;
    always @(posedge clk) tb_pwm <= rst ? 4'd0 : tb_pwm + 4'd1;
`endif

    function automatic logic [3:0] vis(input logic [3:0] p);
`ifdef LED_PATTERN_PWM_EN
        return p & {4{tb_pwm < duty}};
`else
        return p;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] l, input logic w, input int g);
        exp_t e;
        e.leds = l;
        e.wrap = w;
        e.gap  = g;
        sb.push_back(e);
    endtask

    // Wait for each tick, then compare the post-step leds/wrap against the queue.
    task automatic run_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            int   cnt;
            exp_t e;
            cnt = 0;
            while (!tick && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            e = sb.pop_front();
            check({tag, "_gap"}, cnt, e.gap);
            @(negedge clk);
            check({tag, "_leds"}, leds, vis(e.leds));
            check({tag, "_wrap"}, wrap, e.wrap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int lit;

        // Rotate left, full period 16 cycles
        mode = 2'd0; dir = 1'b1; speed = 3'd0; en = 1'b1;
        do_reset();
        check("rst_leds", leds, vis(4'b0001));
        check("rst_wrap", wrap, 1'b0);
        check("rst_tick", tick, 1'b0);
        push(4'b0010, 0, 15); push(4'b0100, 0, 15);
        push(4'b1000, 0, 15); push(4'b0001, 1, 15);
        run_steps("rot", 4);
        @(negedge clk);
        check("rot_wrap_single", wrap, 1'b0);

        // Bounce at speed 2
        mode = 2'd1; speed = 3'd2;
        @(negedge clk);
        check("bnc_start", leds, vis(4'b0001));
        push(4'b0010, 0, 3); push(4'b0100, 0, 3); push(4'b1000, 0, 3);
        push(4'b0100, 0, 3); push(4'b0010, 0, 3); push(4'b0001, 1, 3);
        run_steps("bnc", 6);

        // Fill/drain from MSB, then from LSB
        mode = 2'd2; dir = 1'b0;
        @(negedge clk);
        check("fill_start", leds, vis(4'b0000));
        push(4'b1000, 0, 3); push(4'b1100, 0, 3); push(4'b1110, 0, 3); push(4'b1111, 0, 3);
        push(4'b0111, 0, 3); push(4'b0011, 0, 3); push(4'b0001, 0, 3); push(4'b0000, 1, 3);
        run_steps("fill_msb", 8);
        dir = 1'b1;
        push(4'b0001, 0, 3); push(4'b0011, 0, 3); push(4'b0111, 0, 3); push(4'b1111, 0, 3);
        push(4'b1110, 0, 3); push(4'b1100, 0, 3); push(4'b1000, 0, 3); push(4'b0000, 1, 3);
        run_steps("fill_lsb", 8);

        // Count down from 0, speed change lands on next reload, then count up through wrap
        mode = 2'd3; dir = 1'b0;
        @(negedge clk);
        check("cnt_start", leds, vis(4'b0000));
        push(4'b1111, 1, 3); push(4'b1110, 0, 3);
        run_steps("cnt_dn", 2);
        speed = 3'd7;
        push(4'b1101, 0, 3); push(4'b1100, 0, 0); push(4'b1011, 0, 0);
        run_steps("cnt_fast", 3);
        dir = 1'b1;
        push(4'b1100, 0, 0); push(4'b1101, 0, 0); push(4'b1110, 0, 0);
        push(4'b1111, 0, 0); push(4'b0000, 1, 0);
        run_steps("cnt_up", 5);
        @(negedge clk);
        check("cnt_wrap_single", wrap, 1'b0);

        // Mode change wins over a pending tick; enable freeze mid-rotate
        mode = 2'd0; speed = 3'd0; dir = 1'b1;
        @(negedge clk);
        check("rot2_start", leds, vis(4'b0001));
        push(4'b0010, 0, 15); push(4'b0100, 0, 15);
        run_steps("rot2", 2);
        repeat (5) @(negedge clk);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tick !== 1'b0 || leds !== vis(4'b0100) || wrap !== 1'b0) bad++;
        end
        check("freeze", bad, 0);
        en = 1'b1;
        push(4'b1000, 0, 10);
        run_steps("unfreeze", 1);

        // Mode change while disabled
        en = 1'b0; mode = 2'd2;
        @(negedge clk);
        check("mchg_dis_leds", leds, vis(4'b0000));
        check("mchg_dis_tick", tick, 1'b0);

        // Reset in the middle of a bounce returns to 0001 moving up
        mode = 2'd1; speed = 3'd2; en = 1'b1;
        @(negedge clk);
        check("bnc2_start", leds, vis(4'b0001));
        push(4'b0010, 0, 3); push(4'b0100, 0, 3); push(4'b1000, 0, 3);
        run_steps("bnc2", 3);
        do_reset();
        check("rst_bnc_leds", leds, vis(4'b0001));
        check("rst_bnc_wrap", wrap, 1'b0);
        push(4'b0010, 0, 3);
        run_steps("bnc_up", 1);

`ifdef LED_PATTERN_PWM_EN
        // Hold pattern at 1111 and observe brightness
        mode = 2'd3; dir = 1'b0; speed = 3'd7;
        @(negedge clk);
        push(4'b1111, 1, 0);
        run_steps("pwm_pat", 1);
        en = 1'b0;
        duty = 4'd4;
        lit = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (leds == 4'b1111) lit++;
            else if (leds != 4'b0000) bad++;
        end
        check("pwm_duty4_lit", lit, 4);
        check("pwm_duty4_shape", bad, 0);
        duty = 4'd0;
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (leds != 4'b0000) lit++;
        end
        check("pwm_duty0_dark", lit, 0);
`else
        lit = 0;
        bad = 0;
`endif

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
